button_event_arbiter: RTL and testbench

- Sits downstream of the per-button synchronize/debounce/edge-detect chain.
- Collects one-cycle press pulses from WIDTH buttons and remembers each one as pending.
- Serializes pending presses into a single event stream using round-robin arbitration and a valid/ready handshake.
- The consumer, such as the counter/display controller, sees one button event at a time and never loses a press unless a button re-fires before its previous press was taken.

---
 rtl/button_pkg.sv | 11 +
 rtl/button_event_arbiter_rr_picker.sv | 36 +++
 rtl/button_event_arbiter.sv | 85 ++++++++
 tb/tb_button_event_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared constants and helpers for the button event path.
package button_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Advance an index by one, wrapping at width.
  function automatic int unsigned idx_inc(input int unsigned idx, input int unsigned width);
    return (idx + 32'd1 >= width) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/button_event_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_picker
  import button_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [WIDTH-1:0] rot;
  logic [IDX_W-1:0] off;
  int unsigned      start;

  // Rotate so the slot after 'last' sits at bit 0, priority-encode, then un-rotate.
  always_comb begin
    start = idx_inc(32'(last), WIDTH);
    rot   = '0;
    off   = '0;
    any   = 1'b0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      rot[IDX_W'(k)] = req[IDX_W'((start + k) % WIDTH)];
    end
    for (int unsigned k = 0; k < WIDTH; k++) begin
      if (!any && rot[IDX_W'(k)]) begin
        any = 1'b1;
        off = IDX_W'(k);
      end
    end
    idx = IDX_W'((start + 32'(off)) % WIDTH);
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Latches button press pulses as pending and serializes them round-robin
// into a single valid/ready event stream with per-button overflow flags.
module button_event_arbiter
  import button_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pulse_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_id,
  output logic [WIDTH-1:0] pending,
  output logic [WIDTH-1:0] overflow,
  input  logic             ovf_clear
);

  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] overflow_q, overflow_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] id_q, id_d;
  logic [IDX_W-1:0] rr_last_q, rr_last_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             load_ok;
  logic             grant;
  logic [WIDTH-1:0] load_mask;

  rr_picker #(.WIDTH(WIDTH)) u_picker (
    .req  (pending_q),
    .last (rr_last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Output slot refills whenever it is empty or being drained this cycle.
  always_comb begin
    load_ok   = !valid_q || evt_ready;
    grant     = load_ok && pick_any;
    load_mask = '0;
    if (grant) begin
      load_mask[pick_idx] = 1'b1;
    end

    // A fresh pulse re-arms its bit even when the old press is loaded this cycle.
    pending_d  = (pending_q & ~load_mask) | pulse_in;
    overflow_d = (ovf_clear ? '0 : overflow_q) | (pulse_in & pending_q & ~load_mask);

    valid_d   = valid_q;
    id_d      = id_q;
    rr_last_d = rr_last_q;
    if (load_ok) begin
      valid_d = pick_any;
      if (pick_any) begin
        id_d      = pick_idx;
        rr_last_d = pick_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      overflow_q <= '0;
      valid_q    <= 1'b0;
      id_q       <= '0;
      rr_last_q  <= IDX_W'(WIDTH - 1);
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      id_q       <= id_d;
      rr_last_q  <= rr_last_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_id    = id_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: directed vector table, reset corner cases,
// and randomized traffic against a behavioural model.
module tb_button_event_arbiter;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] pulse_in;
  logic         evt_valid;
  logic         evt_ready;
  logic [1:0]   evt_id;
  logic [W-1:0] pending;
  logic [W-1:0] overflow;
  logic         ovf_clear;

  int tests;
  int fails;

  button_event_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pulse_in  (pulse_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .pending   (pending),
    .overflow  (overflow),
    .ovf_clear (ovf_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pulse;
    logic       ready;
    logic       clr;
    logic       v;
    logic [1:0] id;
    logic [3:0] pend;
    logic [3:0] ovf;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state
  logic [3:0] m_pend;
  logic [3:0] m_ovf;
  logic       m_valid;
  int         m_id;
  int         m_rr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] p, input logic r, input logic c,
                     input logic v, input logic [1:0] id, input logic [3:0] pe, input logic [3:0] ov);
    vec_t t;
    t.pulse = p; t.ready = r; t.clr = c; t.v = v; t.id = id; t.pend = pe; t.ovf = ov;
    vecs.push_back(t);
  endtask

  task automatic m_reset();
    m_pend = '0; m_ovf = '0; m_valid = 1'b0; m_id = 0; m_rr = W - 1;
  endtask

  // One clock of the arbiter described from its rules, not its structure.
  task automatic m_step(input logic [3:0] p, input logic r, input logic c);
    int         win;
    logic [3:0] np;
    logic [3:0] lost;
    bit         free;
    free = !m_valid || r;
    win  = -1;
    if (free) begin
      for (int k = 1; k <= int'(W); k++) begin
        int j;
        j = (m_rr + k) % W;
        if (win < 0 && m_pend[j]) win = j;
      end
    end
    np   = m_pend;
    lost = '0;
    if (win >= 0) np[win] = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      if (p[i]) begin
        if (m_pend[i] && i != win) lost[i] = 1'b1;
        np[i] = 1'b1;
      end
    end
    m_pend = np;
    m_ovf  = (c ? 4'b0000 : m_ovf) | lost;
    if (free) begin
      m_valid = (win >= 0);
      if (win >= 0) begin
        m_id = win;
        m_rr = win;
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; pulse_in = '0; evt_ready = 1'b1; ovf_clear = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 32'({evt_valid, evt_id, pending, overflow}), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Idle after reset
    for (int c = 0; c < 20; c++) begin
      tick();
      check($sformatf("idle_%0d", c), 32'({evt_valid, pending, overflow}), 32'd0);
    end

    // Simultaneous presses from reset: 0,1,3
    add(4'b1011, 1, 0, 0, 2'd0, 4'b1011, 4'b0000);
    add(4'b0000, 1, 0, 1, 2'd0, 4'b1010, 4'b0000);
    add(4'b0000, 1, 0, 1, 2'd1, 4'b1000, 4'b0000);
    add(4'b0000, 1, 0, 1, 2'd3, 4'b0000, 4'b0000);
    add(4'b0000, 1, 0, 0, 2'd3, 4'b0000, 4'b0000);
    // Single press latency
    add(4'b0100, 1, 0, 0, 2'd3, 4'b0100, 4'b0000);
    add(4'b0000, 1, 0, 1, 2'd2, 4'b0000, 4'b0000);
    add(4'b0000, 1, 0, 0, 2'd2, 4'b0000, 4'b0000);
    // Backpressure then round robin 3 -> 0
    add(4'b0001, 0, 0, 0, 2'd2, 4'b0001, 4'b0000);
    add(4'b0010, 0, 0, 1, 2'd0, 4'b0010, 4'b0000);
    add(4'b0000, 0, 0, 1, 2'd0, 4'b0010, 4'b0000);
    add(4'b0000, 0, 0, 1, 2'd0, 4'b0010, 4'b0000);
    add(4'b0000, 1, 0, 1, 2'd1, 4'b0000, 4'b0000);
    add(4'b1001, 0, 0, 1, 2'd1, 4'b1001, 4'b0000);
    add(4'b0000, 1, 0, 1, 2'd3, 4'b0001, 4'b0000);
    add(4'b0000, 1, 0, 1, 2'd0, 4'b0000, 4'b0000);
    add(4'b0000, 1, 0, 0, 2'd0, 4'b0000, 4'b0000);
    // Overflow on bit 1 while output occupied
    add(4'b0001, 0, 0, 0, 2'd0, 4'b0001, 4'b0000);
    add(4'b0010, 0, 0, 1, 2'd0, 4'b0010, 4'b0000);
    add(4'b0010, 0, 0, 1, 2'd0, 4'b0010, 4'b0010);
    add(4'b0000, 1, 0, 1, 2'd1, 4'b0000, 4'b0010);
    add(4'b0000, 1, 0, 0, 2'd1, 4'b0000, 4'b0010);
    // Same-cycle load and pulse, then clear
    add(4'b0010, 0, 0, 0, 2'd1, 4'b0010, 4'b0010);
    add(4'b0010, 0, 0, 1, 2'd1, 4'b0010, 4'b0010);
    add(4'b0000, 0, 1, 1, 2'd1, 4'b0010, 4'b0000);
    add(4'b0000, 1, 0, 1, 2'd1, 4'b0000, 4'b0000);
    add(4'b0000, 1, 0, 0, 2'd1, 4'b0000, 4'b0000);
    // Overflow set beats a same-cycle clear
    add(4'b0001, 0, 0, 0, 2'd1, 4'b0001, 4'b0000);
    add(4'b0001, 0, 0, 1, 2'd0, 4'b0001, 4'b0000);
    add(4'b0001, 0, 1, 1, 2'd0, 4'b0001, 4'b0001);
    add(4'b0000, 1, 1, 1, 2'd0, 4'b0000, 4'b0000);
    add(4'b0000, 1, 0, 0, 2'd0, 4'b0000, 4'b0000);

    foreach (vecs[n]) begin
      pulse_in = vecs[n].pulse; evt_ready = vecs[n].ready; ovf_clear = vecs[n].clr;
      tick();
      check($sformatf("vec%0d_valid", n), 32'(evt_valid), 32'(vecs[n].v));
      check($sformatf("vec%0d_pending", n), 32'(pending), 32'(vecs[n].pend));
      check($sformatf("vec%0d_overflow", n), 32'(overflow), 32'(vecs[n].ovf));
      if (vecs[n].v) check($sformatf("vec%0d_id", n), 32'(evt_id), 32'(vecs[n].id));
    end
    pulse_in = '0; ovf_clear = 1'b0;

    // Async reset with a full backlog and an event in flight (rr_last is 0 here)
    evt_ready = 1'b0; pulse_in = 4'b1111;
    tick();
    pulse_in = 4'b0010;
    tick();
    check("pre_rst_state", 32'({evt_valid, evt_id, pending}), 32'({1'b1, 2'd1, 4'b1111}));
    pulse_in = '0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_clear", 32'({evt_valid, evt_id, pending, overflow}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    evt_ready = 1'b1; pulse_in = 4'b1111;
    tick();
    check("post_rst_pend", 32'({evt_valid, pending}), 32'({1'b0, 4'b1111}));
    pulse_in = '0;
    tick();
    check("post_rst_first", 32'({evt_valid, evt_id}), 32'({1'b1, 2'd0}));

    // Randomized traffic against the model
    rst_n = 1'b0;
    #1;
    m_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      logic [3:0] p;
      logic       r;
      logic       cl;
      p  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      r  = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 15) == 0);
      pulse_in = p; evt_ready = r; ovf_clear = cl;
      tick();
      m_step(p, r, cl);
      check($sformatf("rnd%0d_valid", c), 32'(evt_valid), 32'(m_valid));
      check($sformatf("rnd%0d_pending", c), 32'(pending), 32'(m_pend));
      check($sformatf("rnd%0d_overflow", c), 32'(overflow), 32'(m_ovf));
      if (m_valid) check($sformatf("rnd%0d_id", c), 32'(evt_id), 32'(m_id));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
